// File: rtl/user_input_pkg.sv
// Shared constants and width helper for the user input conditioner.
package user_input_pkg;

    localparam int DEF_TICK_CYCLES  = 50000;
    localparam int DEF_STABLE_TICKS = 10;

    // Width of a counter that must hold values 0..stable_ticks.
    function automatic int CNT_W(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/input_debounce_bit.sv
// One pin: 2-FF synchroniser, tick-based stability counter, debounced level
// and registered rise/fall pulses.
module input_debounce_bit
    import user_input_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic tick,
    input  logic run,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = CNT_W(STABLE_TICKS);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= RESET_LEVEL;
            sync_b <= RESET_LEVEL;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
        end
    end

    // During start-up db simply follows the synchronised pin on each tick
    // and no pulses are produced; afterwards a change must persist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= RESET_LEVEL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!run) begin
                cnt <= '0;
                if (tick) begin
                    db <= sync_b;
                end
            end else if (sync_b == db) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(STABLE_TICKS - 1)) begin
                    db   <= sync_b;
                    cnt  <= '0;
                    rise <= sync_b;
                    fall <= ~sync_b;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/user_input_conditioner.sv
// Debounces board keys and switches for the HPS conduits; shared prescaler,
// start-up settling window and edge pulses for local fabric logic.
module user_input_conditioner
    import user_input_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int N_SW         = 4,
    parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_KEYS-1:0] key_pin,
    input  logic [N_SW-1:0]   sw_pin,
    output logic [N_KEYS-1:0] keys_db,
    output logic [N_SW-1:0]   sw_db,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_SW-1:0]   sw_change,
    output logic              inputs_valid
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int CW = CNT_W(STABLE_TICKS);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [CW-1:0] start_cnt;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    assign tick = (pre_cnt == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // inputs_valid rises on the cycle after the STABLE_TICKS-th tick and then latches.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            start_cnt    <= '0;
            inputs_valid <= 1'b0;
        end else if (!inputs_valid && tick) begin
            if (start_cnt == CW'(STABLE_TICKS - 1)) begin
                inputs_valid <= 1'b1;
                start_cnt    <= '0;
            end else begin
                start_cnt <= start_cnt + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            input_debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS),
                .RESET_LEVEL (1'b1)
            ) u_key (
                .clk  (clk_clk),
                .rst_n(reset_reset_n),
                .pin  (key_pin[gi]),
                .tick (tick),
                .run  (inputs_valid),
                .db   (keys_db[gi]),
                .rise (key_release[gi]),
                .fall (key_press[gi])
            );
        end
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            input_debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS),
                .RESET_LEVEL (1'b0)
            ) u_sw (
                .clk  (clk_clk),
                .rst_n(reset_reset_n),
                .pin  (sw_pin[gi]),
                .tick (tick),
                .run  (inputs_valid),
                .db   (sw_db[gi]),
                .rise (sw_rise[gi]),
                .fall (sw_fall[gi])
            );
        end
    endgenerate

    assign sw_change = sw_rise | sw_fall;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner with a 4-cycle tick and 3-tick stability.
module tb_user_input_conditioner;

    localparam int TC = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_pin;
    logic [3:0] sw_pin;
    logic [3:0] keys_db;
    logic [3:0] sw_db;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] sw_change;
    logic       inputs_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    user_input_conditioner #(
        .N_KEYS      (4),
        .N_SW        (4),
        .TICK_CYCLES (TC),
        .STABLE_TICKS(ST)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .key_pin      (key_pin),
        .sw_pin       (sw_pin),
        .keys_db      (keys_db),
        .sw_db        (sw_db),
        .key_press    (key_press),
        .key_release  (key_release),
        .sw_change    (sw_change),
        .inputs_valid (inputs_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0]  exp_sw;
        logic        exp_valid;
        logic [11:0] pulses;
        rst_n   = 1'b0;
        key_pin = 4'hF;
        sw_pin  = 4'h5;
        repeat (3) step();
        checks++;
        if (keys_db !== 4'hF) begin errors++; $display("FAIL reset_keys_db got %h exp F", keys_db); end
        checks++;
        if (sw_db !== 4'h0) begin errors++; $display("FAIL reset_sw_db got %h exp 0", sw_db); end
        checks++;
        if (inputs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inputs_valid); end
        rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            exp_sw    = (n >= TC) ? 4'h5 : 4'h0;
            exp_valid = (n >= TC * ST);
            pulses    = {key_press, key_release, sw_change};
            checks++;
            if (sw_db !== exp_sw) begin errors++; $display("FAIL startup_sw_db cyc %0d got %h exp %h", n, sw_db, exp_sw); end
            checks++;
            if (inputs_valid !== exp_valid) begin errors++; $display("FAIL startup_valid cyc %0d got %b exp %b", n, inputs_valid, exp_valid); end
            checks++;
            if (pulses !== 12'h000) begin errors++; $display("FAIL startup_pulses cyc %0d got %h exp 000", n, pulses); end
            checks++;
            if (keys_db !== 4'hF) begin errors++; $display("FAIL startup_keys_db cyc %0d got %h exp F", n, keys_db); end
        end
    endtask

    task automatic test_clean_press();
        int lat;
        lat = 0;
        key_pin[0] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (keys_db[0] === 1'b0) begin
                lat = n;
                checks++;
                if (key_press !== 4'b0001) begin errors++; $display("FAIL press_pulse got %b exp 0001", key_press); end
                break;
            end
            checks++;
            if (key_press !== 4'b0000) begin errors++; $display("FAIL press_early_pulse cyc %0d got %b exp 0000", n, key_press); end
        end
        checks++;
        if (lat < 11 || lat > 14) begin errors++; $display("FAIL press_latency got %0d exp 11..14", lat); end
        step();
        checks++;
        if (key_press !== 4'b0000) begin errors++; $display("FAIL press_width got %b exp 0000", key_press); end
        checks++;
        if (keys_db !== 4'hE) begin errors++; $display("FAIL press_keys_db got %h exp E", keys_db); end

        lat = 0;
        key_pin[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (keys_db[0] === 1'b1) begin
                lat = n;
                checks++;
                if (key_release !== 4'b0001) begin errors++; $display("FAIL release_pulse got %b exp 0001", key_release); end
                break;
            end
            checks++;
            if (key_release !== 4'b0000) begin errors++; $display("FAIL release_early_pulse cyc %0d got %b exp 0000", n, key_release); end
        end
        checks++;
        if (lat < 11 || lat > 14) begin errors++; $display("FAIL release_latency got %0d exp 11..14", lat); end
        step();
        checks++;
        if (key_release !== 4'b0000) begin errors++; $display("FAIL release_width got %b exp 0000", key_release); end
        checks++;
        if (keys_db !== 4'hF) begin errors++; $display("FAIL release_keys_db got %h exp F", keys_db); end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 5 == 0) key_pin[2] = ~key_pin[2];
            step();
            if (keys_db[2] !== 1'b1 || key_press !== 4'b0 || key_release !== 4'b0) bad++;
        end
        key_pin[2] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (keys_db[2] !== 1'b1 || key_press !== 4'b0 || key_release !== 4'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bounce_cycles got %0d bad cycles exp 0", bad); end
        checks++;
        if (keys_db !== 4'hF) begin errors++; $display("FAIL bounce_keys_db got %h exp F", keys_db); end
    endtask

    task automatic test_simultaneous();
        int lat;
        lat = 0;
        sw_pin = 4'hA;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (sw_change !== 4'h0) begin
                lat = n;
                checks++;
                if (sw_change !== 4'hF) begin errors++; $display("FAIL sim_change got %h exp F", sw_change); end
                checks++;
                if (sw_db !== 4'hA) begin errors++; $display("FAIL sim_sw_db got %h exp A", sw_db); end
                break;
            end
        end
        checks++;
        if (lat < 11 || lat > 14) begin errors++; $display("FAIL sim_latency got %0d exp 11..14", lat); end
        step();
        checks++;
        if (sw_change !== 4'h0) begin errors++; $display("FAIL sim_width got %h exp 0", sw_change); end
        checks++;
        if (sw_db !== 4'hA) begin errors++; $display("FAIL sim_hold got %h exp A", sw_db); end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  exp_keys;
        logic [3:0]  exp_sw;
        logic        exp_valid;
        logic [11:0] pulses;
        int          bad;
        key_pin[1] = 1'b0;
        // Ten cycles in, exactly two ticks have been counted for this bit.
        repeat (10) step();
        checks++;
        if (keys_db !== 4'hF) begin errors++; $display("FAIL mid_pending got %h exp F", keys_db); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (keys_db !== 4'hF) begin errors++; $display("FAIL mid_rst_keys got %h exp F", keys_db); end
        checks++;
        if (inputs_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", inputs_valid); end
        checks++;
        if (sw_db !== 4'h0) begin errors++; $display("FAIL mid_rst_sw got %h exp 0", sw_db); end
        repeat (2) step();
        rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            exp_keys  = (n >= TC) ? 4'hD : 4'hF;
            exp_sw    = (n >= TC) ? 4'hA : 4'h0;
            exp_valid = (n >= TC * ST);
            pulses    = {key_press, key_release, sw_change};
            checks++;
            if (keys_db !== exp_keys) begin errors++; $display("FAIL restart_keys cyc %0d got %h exp %h", n, keys_db, exp_keys); end
            checks++;
            if (sw_db !== exp_sw) begin errors++; $display("FAIL restart_sw cyc %0d got %h exp %h", n, sw_db, exp_sw); end
            checks++;
            if (inputs_valid !== exp_valid) begin errors++; $display("FAIL restart_valid cyc %0d got %b exp %b", n, inputs_valid, exp_valid); end
            checks++;
            if (pulses !== 12'h000) begin errors++; $display("FAIL restart_pulses cyc %0d got %h exp 000", n, pulses); end
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if ({key_press, key_release, sw_change} !== 12'h000 || keys_db !== 4'hD) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL restart_stale got %0d bad cycles exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
